// File: rtl/schoening_ctrl.sv
// Sequencing FSM for the Schoening random-walk SAT datapath: owns the candidate
// assignment, drives the clause-store read index and flips one variable per iteration.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; found/assign_out hold the last result
// LOAD  | load a fresh random assignment, count a new try
// EVAL  | check evaluator; finish, retry, or pick an unsatisfied clause
// FETCH | wait for the clause store to return the selected mask
// FLIP  | flip one random variable of the selected clause
// DONE  | one-cycle done pulse, then back to IDLE
module schoening_ctrl #(
   parameter int N     = 4,
   parameter int M     = 4,
   parameter int FLIPS = 8,
   parameter int TRIES = 16,
   parameter int RW    = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [RW-1:0]             rand_val,
   input  logic [M-1:0]              clauses_sat,
   output logic [$clog2(M)-1:0]      clause_rd_idx,
   input  logic [N-1:0]              clause_vars,
   output logic [N-1:0]              assign_out,
   output logic                      busy,
   output logic                      done,
   output logic                      found,
   output logic [$clog2(TRIES):0]    try_cnt
);

   localparam int CW = $clog2(M);
   localparam int VW = $clog2(N);
   localparam int TW = $clog2(TRIES) + 1;
   localparam int FW = $clog2(FLIPS) + 1;
   localparam logic [TW-1:0] TRIES_C = TW'(TRIES);
   localparam logic [FW-1:0] FLIPS_C = FW'(FLIPS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_EVAL,
      S_FETCH,
      S_FLIP,
      S_DONE
   } state_t;

   state_t          state, state_nxt;
   logic [N-1:0]    assign_nxt;
   logic [CW-1:0]   idx_nxt;
   logic [TW-1:0]   try_nxt;
   logic [FW-1:0]   flip_cnt, flip_nxt;
   logic            found_nxt;
   logic            unused_rand;

   // Only the low bits of the random word are consumed.
   assign unused_rand = ^rand_val;

   // First unsatisfied clause scanning upward from r with wrap-around.
   function automatic logic [CW-1:0] pick_clause(input logic [M-1:0] sat, input logic [CW-1:0] r);
      logic [CW-1:0] j;
      logic [CW-1:0] sel;
      logic          hit;
      sel = r;
      hit = 1'b0;
      for (int i = 0; i < M; i++) begin
         j = r + CW'(i);
         if (!hit && !sat[j]) begin
            sel = j;
            hit = 1'b1;
         end
      end
      return sel;
   endfunction

   // One-hot mask of the first set variable from v upward; zero for an empty clause.
   function automatic logic [N-1:0] flip_mask(input logic [N-1:0] vars, input logic [VW-1:0] v);
      logic [VW-1:0] k;
      logic [N-1:0]  m;
      logic          hit;
      m   = '0;
      hit = 1'b0;
      for (int i = 0; i < N; i++) begin
         k = v + VW'(i);
         if (!hit && vars[k]) begin
            m[k] = 1'b1;
            hit  = 1'b1;
         end
      end
      return m;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         assign_out    <= '0;
         clause_rd_idx <= '0;
         try_cnt       <= '0;
         flip_cnt      <= '0;
         found         <= 1'b0;
      end else begin
         state         <= state_nxt;
         assign_out    <= assign_nxt;
         clause_rd_idx <= idx_nxt;
         try_cnt       <= try_nxt;
         flip_cnt      <= flip_nxt;
         found         <= found_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      assign_nxt = assign_out;
      idx_nxt    = clause_rd_idx;
      try_nxt    = try_cnt;
      flip_nxt   = flip_cnt;
      found_nxt  = found;
      case (state)
         S_IDLE: begin
            if (start) begin
               found_nxt = 1'b0;
               try_nxt   = '0;
               state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            assign_nxt = rand_val[N-1:0];
            flip_nxt   = '0;
            try_nxt    = try_cnt + 1'b1;
            state_nxt  = S_EVAL;
         end
         S_EVAL: begin
            // Success is checked before the flip limit so a last-flip hit still counts.
            if (&clauses_sat) begin
               found_nxt = 1'b1;
               state_nxt = S_DONE;
            end else if (flip_cnt == FLIPS_C) begin
               state_nxt = (try_cnt == TRIES_C) ? S_DONE : S_LOAD;
            end else begin
               idx_nxt   = pick_clause(clauses_sat, rand_val[CW-1:0]);
               state_nxt = S_FETCH;
            end
         end
         S_FETCH: state_nxt = S_FLIP;
         S_FLIP: begin
            assign_nxt = assign_out ^ flip_mask(clause_vars, rand_val[CW+VW-1:CW]);
            flip_nxt   = flip_cnt + 1'b1;
            state_nxt  = S_EVAL;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_schoening_ctrl.sv
// Self-checking bench for schoening_ctrl: directed single-flip vectors, multi-cycle
// corner sequences and random searches against an algorithmic reference model.
module tb_schoening_ctrl;

   localparam int N     = 4;
   localparam int M     = 4;
   localparam int FLIPS = 8;
   localparam int TRIES = 2;
   localparam int RW    = 32;
   localparam int TW    = $clog2(TRIES) + 1;
   localparam int NC    = 80;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [RW-1:0] rand_val = '0;
   logic [M-1:0]  clauses_sat;
   logic [1:0]    clause_rd_idx;
   logic [N-1:0]  clause_vars = '0;
   logic [N-1:0]  assign_out;
   logic          busy, done, found;
   logic [TW-1:0] try_cnt;

   logic [N-1:0]  cl_pos [M];
   logic [N-1:0]  cl_neg [M];
   logic          sat_ovr_en = 1'b0;
   logic [M-1:0]  sat_ovr = '0;

   // per-cycle stimulus and recorded trace (index = cycle, start sampled at edge 0)
   logic [RW-1:0] rnd      [NC];
   logic          st_v     [NC];
   logic          rs_v     [NC];
   logic          busy_tr  [NC];
   logic          done_tr  [NC];
   logic          found_tr [NC];
   logic [N-1:0]  asg_tr   [NC];
   logic [1:0]    idx_tr   [NC];
   logic [TW-1:0] try_tr   [NC];
   int            done_cnt, done_cyc;

   int total = 0;
   int bad   = 0;

   schoening_ctrl #(.N(N), .M(M), .FLIPS(FLIPS), .TRIES(TRIES), .RW(RW)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .rand_val      (rand_val),
      .clauses_sat   (clauses_sat),
      .clause_rd_idx (clause_rd_idx),
      .clause_vars   (clause_vars),
      .assign_out    (assign_out),
      .busy          (busy),
      .done          (done),
      .found         (found),
      .try_cnt       (try_cnt)
   );

   always #5 clk = ~clk;

   always_comb begin
      clauses_sat = '0;
      for (int i = 0; i < M; i++)
         clauses_sat[i] = |((cl_pos[i] & assign_out) | (cl_neg[i] & ~assign_out));
      if (sat_ovr_en) clauses_sat = sat_ovr;
   end

   // clause store: registered read, valid one cycle after the index changes
   always @(posedge clk) clause_vars <= cl_pos[clause_rd_idx] | cl_neg[clause_rd_idx];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [M-1:0] sat_vec(input logic [N-1:0] a);
      logic [M-1:0] s;
      for (int i = 0; i < M; i++) s[i] = |((cl_pos[i] & a) | (cl_neg[i] & ~a));
      return s;
   endfunction

   task automatic clear_stim();
      for (int k = 0; k < NC; k++) begin
         rnd[k]  = $urandom;
         st_v[k] = 1'b0;
         rs_v[k] = 1'b0;
      end
   endtask

   task automatic set_store(input logic [N-1:0] pos, input logic [N-1:0] neg);
      for (int i = 0; i < M; i++) begin
         cl_pos[i] = pos;
         cl_neg[i] = neg;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic drive(input int k);
      start    = st_v[k];
      reset    = rs_v[k];
      rand_val = rnd[k];
   endtask

   // Fixed-length run: always terminates; a missing done shows up as done_cyc = -1.
   task automatic run(input int ncyc);
      done_cnt = 0;
      done_cyc = -1;
      drive(0);
      for (int k = 1; k <= ncyc; k++) begin
         @(posedge clk);
         #1;
         drive(k);
         busy_tr[k]  = busy;
         done_tr[k]  = done;
         found_tr[k] = found;
         asg_tr[k]   = assign_out;
         idx_tr[k]   = clause_rd_idx;
         try_tr[k]   = try_cnt;
         if (done) begin
            done_cnt++;
            done_cyc = k;
         end
      end
   endtask

   // Algorithmic search with explicit cycle bookkeeping: LOAD 1 cycle, then per flip EVAL/FETCH/FLIP.
   task automatic model(output int e_cyc, output logic e_found, output logic [N-1:0] e_asg, output int e_try);
      int c, tries, j, kk;
      logic [N-1:0] a, vars, s;
      c = 1; tries = 0; e_found = 1'b0; e_cyc = -1; a = '0;
      while (1) begin
         tries++;
         a = rnd[c][N-1:0];
         c++;
         for (int f = 0; f <= FLIPS; f++) begin
            s = sat_vec(a);
            if (s == '1) begin
               e_found = 1'b1;
               break;
            end
            if (f == FLIPS) break;
            j = 0;
            for (int i = M - 1; i >= 0; i--)
               if (!s[(int'(rnd[c][1:0]) + i) % M]) j = (int'(rnd[c][1:0]) + i) % M;
            c += 2;
            vars = cl_pos[j] | cl_neg[j];
            kk = -1;
            for (int i = N - 1; i >= 0; i--)
               if (vars[(int'(rnd[c][3:2]) + i) % N]) kk = (int'(rnd[c][3:2]) + i) % N;
            if (kk >= 0) a[kk] = ~a[kk];
            c++;
         end
         if (e_found || tries == TRIES) begin
            e_cyc = c + 1;
            break;
         end
         c++;
      end
      e_asg = a;
      e_try = tries;
   endtask

   typedef struct {
      logic [3:0] a0;
      logic [3:0] sat;
      logic [1:0] r;
      logic [3:0] vars;
      logic [1:0] v;
      logic [1:0] exp_idx;
      logic [3:0] exp_a;
   } vec_t;

   vec_t vt [6];

   initial begin
      int           e_cyc, e_try;
      logic         e_found;
      logic [N-1:0] e_asg;

      vt[0] = '{4'b0000, 4'b1011, 2'd3, 4'b0110, 2'd3, 2'd2, 4'b0010};
      vt[1] = '{4'b1111, 4'b0000, 2'd1, 4'b1000, 2'd0, 2'd1, 4'b0111};
      vt[2] = '{4'b0101, 4'b1110, 2'd2, 4'b0000, 2'd2, 2'd0, 4'b0101};
      vt[3] = '{4'b1010, 4'b0111, 2'd0, 4'b1111, 2'd2, 2'd3, 4'b1110};
      vt[4] = '{4'b0011, 4'b1101, 2'd2, 4'b0011, 2'd2, 2'd1, 4'b0010};
      vt[5] = '{4'b1000, 4'b0101, 2'd3, 4'b1001, 2'd1, 2'd3, 4'b0000};

      set_store('0, '0);
      do_reset();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_found", 32'(found), 0);
      chk("rst_assign", 32'(assign_out), 0);
      chk("rst_idx", 32'(clause_rd_idx), 0);
      chk("rst_try", 32'(try_cnt), 0);

      // single-flip vectors: clause selection and variable flip
      sat_ovr_en = 1'b1;
      for (int t = 0; t < 6; t++) begin
         clear_stim();
         set_store(vt[t].vars, '0);
         sat_ovr = vt[t].sat;
         st_v[0] = 1'b1;
         rnd[1][3:0] = vt[t].a0;
         rnd[2][1:0] = vt[t].r;
         rnd[4][3:2] = vt[t].v;
         do_reset();
         run(6);
         chk($sformatf("vec%0d_load", t), 32'(asg_tr[2]), 32'(vt[t].a0));
         chk($sformatf("vec%0d_idx", t), 32'(idx_tr[3]), 32'(vt[t].exp_idx));
         chk($sformatf("vec%0d_flip", t), 32'(asg_tr[5]), 32'(vt[t].exp_a));
      end

      // exhaustion with empty clauses; start pulses in EVAL and DONE are ignored
      clear_stim();
      set_store('0, '0);
      sat_ovr = '0;
      st_v[0] = 1'b1; st_v[2] = 1'b1; st_v[5] = 1'b1; st_v[53] = 1'b1;
      do_reset();
      run(58);
      begin
         int busy_bad;
         busy_bad = 0;
         for (int k = 1; k <= 53; k++) if (busy_tr[k] !== 1'b1) busy_bad++;
         chk("exh_busy_span", 32'(busy_bad), 0);
      end
      chk("exh_done_cnt", 32'(done_cnt), 1);
      chk("exh_done_cyc", 32'(done_cyc), 53);
      chk("exh_found", 32'(found_tr[53]), 0);
      chk("exh_try", 32'(try_tr[53]), 2);
      chk("exh_assign_held", 32'(asg_tr[53]), 32'(rnd[27][3:0]));
      chk("exh_idle54", 32'(busy_tr[54]), 0);
      chk("exh_idle56", 32'(busy_tr[56]), 0);

      // immediate hit, start held through DONE -> second search
      sat_ovr_en = 1'b0;
      clear_stim();
      set_store(4'hF, '0);
      for (int k = 0; k <= 4; k++) st_v[k] = 1'b1;
      rnd[1][3:0] = 4'hF;
      rnd[5][3:0] = 4'hF;
      do_reset();
      run(10);
      chk("hit_done3", 32'(done_tr[3]), 1);
      chk("hit_found", 32'(found_tr[3]), 1);
      chk("hit_assign", 32'(asg_tr[3]), 32'hF);
      chk("hit_try", 32'(try_tr[3]), 1);
      chk("hit_found_held", 32'(found_tr[4]), 1);
      chk("hit_found_clr", 32'(found_tr[5]), 0);
      chk("hit_try_clr", 32'(try_tr[5]), 0);
      chk("hit2_busy", 32'(busy_tr[5]), 1);
      chk("hit2_done7", 32'(done_tr[7]), 1);
      chk("hit2_try", 32'(try_tr[7]), 1);
      chk("hit_done_cnt", 32'(done_cnt), 2);

      // reset during FETCH of try 1
      sat_ovr_en = 1'b1;
      sat_ovr = '0;
      clear_stim();
      set_store(4'b0101, '0);
      st_v[0] = 1'b1;
      rnd[1][3:0] = 4'hA;
      rnd[2][1:0] = 2'd2;
      rs_v[3] = 1'b1;
      do_reset();
      run(40);
      chk("rstm_fetch_idx", 32'(idx_tr[3]), 2);
      chk("rstm_fetch_busy", 32'(busy_tr[3]), 1);
      chk("rstm_busy", 32'(busy_tr[4]), 0);
      chk("rstm_assign", 32'(asg_tr[4]), 0);
      chk("rstm_try", 32'(try_tr[4]), 0);
      chk("rstm_idx", 32'(idx_tr[4]), 0);
      chk("rstm_no_done", 32'(done_cnt), 0);

      // random formulas and random words against the reference model
      sat_ovr_en = 1'b0;
      for (int t = 0; t < 25; t++) begin
         clear_stim();
         for (int i = 0; i < M; i++) begin
            cl_pos[i] = 4'($urandom);
            cl_neg[i] = 4'($urandom) & ~cl_pos[i];
         end
         st_v[0] = 1'b1;
         model(e_cyc, e_found, e_asg, e_try);
         do_reset();
         run(60);
         chk($sformatf("rnd%0d_done_cnt", t), 32'(done_cnt), 1);
         chk($sformatf("rnd%0d_done_cyc", t), 32'(done_cyc), 32'(e_cyc));
         if (done_cyc > 0) begin
            chk($sformatf("rnd%0d_found", t), 32'(found_tr[done_cyc]), 32'(e_found));
            chk($sformatf("rnd%0d_assign", t), 32'(asg_tr[done_cyc]), 32'(e_asg));
            chk($sformatf("rnd%0d_try", t), 32'(try_tr[done_cyc]), 32'(e_try));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
